// File: rtl/ro_scan_sequencer.sv
// ro_scan_sequencer: scans a ring-oscillator bank (settle, gate, drain, capture) and streams counts out over valid/ready.
// Define SCAN_CONTINUOUS_EN to restart the scan automatically after the last oscillator.
module ro_scan_sequencer #(
  parameter int NUM_RO        = 125,
  parameter int IDX_W         = 7,
  parameter int SETTLE_CYCLES = 1000,
  parameter int WINDOW_CYCLES = 200000,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [IDX_W-1:0] ro_sel_o,
  output logic             ro_en_o,
  output logic             cnt_clr_o,
  output logic             cnt_gate_o,
  input  logic [31:0]      cnt_value_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [IDX_W-1:0] res_index_o,
  output logic [31:0]      res_data_o,
  output logic             busy_o,
  output logic             scan_done_o
);
  localparam int MAX_SW = SETTLE_CYCLES > WINDOW_CYCLES ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int MAX_C  = MAX_SW > DRAIN_CYCLES ? MAX_SW : DRAIN_CYCLES;
  localparam int TW     = MAX_C > 1 ? $clog2(MAX_C) : 1;
`ifdef SCAN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DRAIN, SEND} state_t;
  state_t           state_q;
  logic [TW-1:0]    tmr_q;
  logic [IDX_W-1:0] ro_sel_q, res_index_q;
  logic [31:0]      res_data_q;
  logic             ro_en_q, cnt_clr_q, cnt_gate_q, res_valid_q, scan_done_q;
  logic             last;
  assign last = ro_sel_q == IDX_W'(NUM_RO - 1);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      ro_sel_q    <= '0;
      ro_en_q     <= 1'b0;
      cnt_clr_q   <= 1'b0;
      cnt_gate_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      scan_done_q <= 1'b0;
    end else if (abort_i) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      ro_sel_q    <= '0;
      ro_en_q     <= 1'b0;
      cnt_clr_q   <= 1'b0;
      cnt_gate_q  <= 1'b0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      cnt_clr_q   <= 1'b0;
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q   <= SETTLE;
          ro_sel_q  <= '0;
          ro_en_q   <= 1'b1;
          cnt_clr_q <= 1'b1;
          tmr_q     <= TW'(SETTLE_CYCLES - 1);
        end
        SETTLE: if (tmr_q == '0) begin
          state_q    <= MEASURE;
          cnt_gate_q <= 1'b1;
          tmr_q      <= TW'(WINDOW_CYCLES - 1);
        end else tmr_q <= tmr_q - 1'b1;
        MEASURE: if (tmr_q == '0) begin
          state_q    <= DRAIN;
          cnt_gate_q <= 1'b0;
          ro_en_q    <= 1'b0;
          tmr_q      <= TW'(DRAIN_CYCLES - 1);
        end else tmr_q <= tmr_q - 1'b1;
        DRAIN: if (tmr_q == '0) begin
          state_q     <= SEND;
          res_data_q  <= cnt_value_i;
          res_index_q <= ro_sel_q;
          res_valid_q <= 1'b1;
        end else tmr_q <= tmr_q - 1'b1;
        SEND: if (res_ready_i) begin
          // after the last RO either stop, or wrap to index 0 when running continuously
          res_valid_q <= 1'b0;
          scan_done_q <= last;
          ro_sel_q    <= last ? '0 : ro_sel_q + 1'b1;
          state_q     <= (last && !CONT) ? IDLE : SETTLE;
          ro_en_q     <= !last || CONT;
          cnt_clr_q   <= !last || CONT;
          tmr_q       <= TW'(SETTLE_CYCLES - 1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ro_sel_o    = ro_sel_q;
  assign ro_en_o     = ro_en_q;
  assign cnt_clr_o   = cnt_clr_q;
  assign cnt_gate_o  = cnt_gate_q;
  assign res_valid_o = res_valid_q;
  assign res_index_o = res_index_q;
  assign res_data_o  = res_data_q;
  assign scan_done_o = scan_done_q;
  assign busy_o      = state_q != IDLE;
endmodule
